bsg_manycore_store_ack_tracker: RTL

//  Per-tile return-network endpoint between the proc and the proc port (P) of the return mesh router.

---
 rtl/bsg_manycore_store_ack_tracker.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_store_ack_tracker.sv
// Per-tile store-ack endpoint: queues acks for accepted remote stores and counts this tile's outstanding stores.
// Ack latency 1 cycle from enqueue to ret_v_o; req_in_ready_o drops when the ack FIFO is full.

module bsg_manycore_store_ack_fifo #(
  parameter int width_p = 15,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq,
  input  logic [width_p-1:0] enq_data,
  input  logic               deq,
  output logic               full,
  output logic               empty,
  output logic [width_p-1:0] head
);
  localparam int pw = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [pw-1:0] last_ptr = pw'(els_p - 1);

  logic [width_p-1:0] mem [els_p];
  logic [pw-1:0]      wptr, rptr;
  logic               last_enq;
  logic               do_enq, do_deq;

  function automatic logic [pw-1:0] bump(input logic [pw-1:0] p);
    return (p == last_ptr) ? '0 : p + pw'(1);
  endfunction

  // Equal pointers mean full if the last occupancy change was an enqueue.
  assign full   = (wptr == rptr) & last_enq;
  assign empty  = (wptr == rptr) & ~last_enq;
  assign do_enq = enq & ~full;
  assign do_deq = deq & ~empty;
  assign head   = mem[rptr];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr     <= '0;
      rptr     <= '0;
      last_enq <= 1'b0;
      for (int i = 0; i < els_p; i++) mem[i] <= '0;
    end else begin
      if (do_enq) begin
        mem[wptr] <= enq_data;
        wptr      <= bump(wptr);
      end
      if (do_deq) rptr <= bump(rptr);
      if (do_enq != do_deq) last_enq <= do_enq;
    end
  end
endmodule

module bsg_manycore_store_ack_tracker #(
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5,
  parameter int ack_fifo_els_p = 2,
  parameter int max_out_p      = 16,
  localparam int ret_w = x_cord_width_p + y_cord_width_p + 5,
  localparam int cw    = $clog2(max_out_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      req_in_v_i,
  input  logic                      req_in_store_i,
  input  logic [x_cord_width_p-1:0] req_in_src_x_i,
  input  logic [y_cord_width_p-1:0] req_in_src_y_i,
  output logic                      req_in_ready_o,
  input  logic                      req_out_fire_i,
  input  logic                      req_out_store_i,
  output logic                      ret_v_o,
  output logic [ret_w-1:0]          ret_data_o,
  input  logic                      ret_ready_i,
  input  logic                      ret_v_i,
  input  logic [ret_w-1:0]          ret_data_i,
  output logic                      ret_ready_o,
  output logic                      credit_avail_o,
  output logic [cw-1:0]             outstanding_o,
  output logic                      stores_done_o,
  output logic                      underflow_o
);
  localparam int ack_bit = x_cord_width_p + y_cord_width_p;
  localparam logic [cw-1:0] max_c = cw'(max_out_p);

  logic            up_r;
  logic            fifo_full, fifo_empty;
  logic            enq, deq;
  logic [ret_w-1:0] enq_data;
  logic [cw-1:0]   count_r;
  logic            underflow_r;
  logic            inc, dec;
  logic            unused_ret_bits;

  // Ready outputs stay low until the first clock edge after reset release.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) up_r <= 1'b0;
    else          up_r <= 1'b1;
  end

  assign req_in_ready_o = up_r & ~fifo_full;
  assign ret_ready_o    = up_r;

  assign enq      = req_in_v_i & req_in_ready_o & req_in_store_i;
  assign enq_data = {5'b00001, req_in_src_y_i, req_in_src_x_i};
  assign ret_v_o  = ~fifo_empty;
  assign deq      = ret_v_o & ret_ready_i;

  bsg_manycore_store_ack_fifo #(
    .width_p (ret_w),
    .els_p   (ack_fifo_els_p)
  ) ack_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .enq      (enq),
    .enq_data (enq_data),
    .deq      (deq),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (ret_data_o)
  );

  assign inc = req_out_fire_i & req_out_store_i;
  assign dec = ret_v_i & ret_ready_o & ret_data_i[ack_bit];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_r     <= '0;
      underflow_r <= 1'b0;
    end else if (inc & ~dec) begin
      if (count_r != max_c) count_r <= count_r + cw'(1);
    end else if (dec & ~inc) begin
      // An ack with nothing outstanding is recorded, never wrapped.
      if (count_r == '0) underflow_r <= 1'b1;
      else               count_r     <= count_r - cw'(1);
    end
  end

  assign outstanding_o  = count_r;
  assign credit_avail_o = (count_r < max_c);
  assign stores_done_o  = (count_r == '0);
  assign underflow_o    = underflow_r;

  assign unused_ret_bits = ^{ret_data_i[ret_w-1:ack_bit+1], ret_data_i[ack_bit-1:0]};
endmodule
